data_mem_ctrl: RTL and testbench

//  Parametrised CPU data memory with a request/ready handshake and configurable read latency.

---
 rtl/cpu_mem_pkg.sv | 27 ++
 rtl/data_mem_ctrl_if.sv | 25 ++
 rtl/data_mem_align.sv | 39 +++
 rtl/data_mem_ctrl.sv | 148 ++++++++++++++
 tb/tb_data_mem_ctrl.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared types and helpers for the CPU data memory controller.
package cpu_mem_pkg;

  localparam int MAX_RD_LATENCY = 4;

  typedef enum logic [1:0] {
    XFER_B = 2'd0,
    XFER_H = 2'd1,
    XFER_W = 2'd2
  } xfer_size_e;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } mem_state_e;

  // Size code 3 is never aligned, so it falls out as a rejection.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      XFER_B:  is_aligned = 1'b1;
      XFER_H:  is_aligned = ~addr_lo[0];
      XFER_W:  is_aligned = (addr_lo == 2'b00);
      default: is_aligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Request/ready bus between the CPU and the data memory.
interface data_mem_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] MEM_addr;
  logic [2:0]        MEM_type;
  logic              MEM_rd_en;
  logic              MEM_wr_en;
  logic [DATA_W-1:0] MEM_WR_out;
  logic              MEM_ready;
  logic [DATA_W-1:0] MEM_data;
  logic              MEM_rvalid;
  logic              MEM_err;

  modport master (
    output MEM_addr, MEM_type, MEM_rd_en, MEM_wr_en, MEM_WR_out,
    input  MEM_ready, MEM_data, MEM_rvalid, MEM_err
  );

  modport slave (
    input  MEM_addr, MEM_type, MEM_rd_en, MEM_wr_en, MEM_WR_out,
    output MEM_ready, MEM_data, MEM_rvalid, MEM_err
  );
endinterface

// File: rtl/data_mem_align.sv
// Byte-lane steering: write enables, write data shift, and load extension.
module data_mem_align
  import cpu_mem_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [4:0]  w_shamt;
  logic [31:0] w_rsh;

  assign w_shamt = {i_addr_lo, 3'b000};

  always_comb begin
    w_rsh   = i_rword >> w_shamt;
    o_wdata = i_wdata << w_shamt;
    o_be    = 4'b0000;
    o_rdata = w_rsh;
    case (i_size)
      XFER_B: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_rdata = i_unsigned ? {24'd0, w_rsh[7:0]} : {{24{w_rsh[7]}}, w_rsh[7:0]};
      end
      XFER_H: begin
        o_be    = 4'b0011 << i_addr_lo;
        o_rdata = i_unsigned ? {16'd0, w_rsh[15:0]} : {{16{w_rsh[15]}}, w_rsh[15:0]};
      end
      XFER_W:  o_be = 4'b1111;
      default: o_be = 4'b0000;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// CPU data memory with request/ready handshake and RD_LATENCY-cycle reads.
// Define DATA_MEM_STATS_EN to add saturating stat_rd/stat_wr/stat_err counters.
//
// state   | meaning
// IDLE    | ready high; accepts reads, writes and rejects
// RD_WAIT | read in flight; ready low until the response cycle
module data_mem_ctrl
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int RD_LATENCY  = 1
) (
  input  logic CLK,
  input  logic Reset_n,
  data_mem_ctrl_if.slave bus
`ifdef DATA_MEM_STATS_EN
  ,
  output logic [15:0] stat_rd,
  output logic [15:0] stat_wr,
  output logic [15:0] stat_err
`endif
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = $clog2(MAX_RD_LATENCY);
  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(4 * DEPTH_WORDS);

  logic [3:0][7:0]   r_mem [DEPTH_WORDS];
  mem_state_e        r_state;
  logic              r_ready;
  logic              r_rvalid;
  logic              r_err;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] r_hold;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_accept;
  logic              w_legal;
  logic              w_rd_go;
  logic              w_wr_go;
  logic              w_rej;
  logic [IDX_W-1:0]  w_idx;
  logic [31:0]       w_rword;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic [31:0]       w_rdata;

  assign w_accept = r_ready & (bus.MEM_rd_en | bus.MEM_wr_en);
  assign w_legal  = is_aligned(bus.MEM_type[1:0], bus.MEM_addr[1:0])
                  & ({1'b0, bus.MEM_addr} < ADDR_LIMIT)
                  & ~(bus.MEM_rd_en & bus.MEM_wr_en);
  assign w_rd_go  = w_accept & w_legal & bus.MEM_rd_en;
  assign w_wr_go  = w_accept & w_legal & bus.MEM_wr_en;
  assign w_rej    = w_accept & ~w_legal;
  assign w_idx    = bus.MEM_addr[IDX_W+1:2];
  assign w_rword  = r_mem[w_idx];

  data_mem_align u_align (
    .i_addr_lo (bus.MEM_addr[1:0]),
    .i_size    (bus.MEM_type[1:0]),
    .i_unsigned(bus.MEM_type[2]),
    .i_wdata   (bus.MEM_WR_out),
    .i_rword   (w_rword),
    .o_be      (w_be),
    .o_wdata   (w_wdata),
    .o_rdata   (w_rdata)
  );

  always_ff @(posedge CLK) begin
    if (w_wr_go) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][b] <= w_wdata[8*b +: 8];
      end
    end
  end

  // Read data is extended at the accepting edge and parked in r_hold until the response cycle.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state  <= IDLE;
      r_ready  <= 1'b1;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_data   <= '0;
      r_hold   <= '0;
      r_cnt    <= '0;
    end else begin
      r_rvalid <= 1'b0;
      r_err    <= w_rej;
      case (r_state)
        IDLE: begin
          if (w_rd_go) begin
            if (RD_LATENCY == 1) begin
              r_data   <= w_rdata;
              r_rvalid <= 1'b1;
            end else begin
              r_hold  <= w_rdata;
              r_cnt   <= CNT_W'(RD_LATENCY - 2);
              r_ready <= 1'b0;
              r_state <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          if (r_cnt == '0) begin
            r_data   <= r_hold;
            r_rvalid <= 1'b1;
            r_ready  <= 1'b1;
            r_state  <= IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.MEM_ready  = r_ready;
  assign bus.MEM_data   = r_data;
  assign bus.MEM_rvalid = r_rvalid;
  assign bus.MEM_err    = r_err;

`ifdef DATA_MEM_STATS_EN
  logic [15:0] r_stat_rd;
  logic [15:0] r_stat_wr;
  logic [15:0] r_stat_err;

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      r_stat_rd  <= '0;
      r_stat_wr  <= '0;
      r_stat_err <= '0;
    end else begin
      if (w_rd_go && r_stat_rd  != 16'hFFFF) r_stat_rd  <= r_stat_rd  + 16'd1;
      if (w_wr_go && r_stat_wr  != 16'hFFFF) r_stat_wr  <= r_stat_wr  + 16'd1;
      if (w_rej   && r_stat_err != 16'hFFFF) r_stat_err <= r_stat_err + 16'd1;
    end
  end

  assign stat_rd  = r_stat_rd;
  assign stat_wr  = r_stat_wr;
  assign stat_err = r_stat_err;
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl with RD_LATENCY=3.
module tb_data_mem_ctrl;

  localparam int L = 3;

  logic CLK = 1'b0;
  logic Reset_n = 1'b0;
  always #5 CLK = ~CLK;

  data_mem_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef DATA_MEM_STATS_EN
  logic [15:0] stat_rd, stat_wr, stat_err;
`endif

  data_mem_ctrl #(
    .ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(1024), .RD_LATENCY(L)
  ) dut (
    .CLK    (CLK),
    .Reset_n(Reset_n),
    .bus    (bus)
`ifdef DATA_MEM_STATS_EN
    ,
    .stat_rd (stat_rd),
    .stat_wr (stat_wr),
    .stat_err(stat_err)
`endif
  );

  typedef struct {
    bit          is_err;
    logic [31:0] data;
    int          cyc;
    string       nm;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int n_rd = 0, n_wr = 0, n_err = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end
  endtask

  task automatic mon_evt(input bit is_err);
    exp_t e;
    tests++;
    if (q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_%s: pulse at cycle %0d, expected none", is_err ? "err" : "rvalid", cyc);
    end else begin
      e = q.pop_front();
      if (e.is_err != is_err || e.cyc != cyc || (!is_err && bus.MEM_data !== e.data)) begin
        fails++;
        $display("FAIL %s: got err=%0d cyc=%0d data=%h expected err=%0d cyc=%0d data=%h",
                 e.nm, is_err, cyc, bus.MEM_data, e.is_err, e.cyc, e.data);
      end
    end
  endtask

  always @(negedge CLK) begin
    if (bus.MEM_rvalid) mon_evt(1'b0);
    if (bus.MEM_err)    mon_evt(1'b1);
  end

  // kind: 0 write, 1 read with expected data, 2 rejected, 3 read whose response is not expected
  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic req(input string nm, input bit rd, input bit wr, input logic [31:0] addr,
                     input logic [2:0] typ, input logic [31:0] wd, input int kind,
                     input logic [31:0] exp_d, output int n0);
    logic [31:0] d_before;
    logic        exp_rdy;
    int          k;
    exp_t        e;
    bus.MEM_addr   = addr;
    bus.MEM_type   = typ;
    bus.MEM_WR_out = wd;
    bus.MEM_rd_en  = rd;
    bus.MEM_wr_en  = wr;
    n0 = -1;
    k = 0;
    while (!bus.MEM_ready && k < 20) begin
      @(negedge CLK);
      k++;
    end
    if (!bus.MEM_ready) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: ready=%b after %0d cycles, required 1", nm, bus.MEM_ready, k);
      bus.MEM_rd_en = 1'b0;
      bus.MEM_wr_en = 1'b0;
      return;
    end
    d_before = bus.MEM_data;
    @(posedge CLK);
    #1;
    n0 = cyc;
    bus.MEM_rd_en = 1'b0;
    bus.MEM_wr_en = 1'b0;
    case (kind)
      0: n_wr++;
      1: begin
        n_rd++;
        e = '{1'b0, exp_d, n0 + L - 1, nm};
        q.push_back(e);
      end
      2: begin
        n_err++;
        e = '{1'b1, 32'd0, n0, nm};
        q.push_back(e);
      end
      default: n_rd++;
    endcase
    @(negedge CLK);
    exp_rdy = ((kind == 1 || kind == 3) && L > 1) ? 1'b0 : 1'b1;
    chk({nm, "_ready"}, {31'd0, bus.MEM_ready}, {31'd0, exp_rdy});
    if (kind == 2) chk({nm, "_data_held"}, bus.MEM_data, d_before);
  endtask

  initial begin
    int n, na, nb, k;
    bus.MEM_addr = '0; bus.MEM_type = '0; bus.MEM_WR_out = '0;
    bus.MEM_rd_en = 1'b0; bus.MEM_wr_en = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_ready",  {31'd0, bus.MEM_ready},  32'd1);
    chk("rst_data",   bus.MEM_data,            32'd0);
    chk("rst_rvalid", {31'd0, bus.MEM_rvalid}, 32'd0);
    chk("rst_err",    {31'd0, bus.MEM_err},    32'd0);
    Reset_n = 1'b1;
    @(negedge CLK);

    req("wr_deadbeef", 0, 1, 32'h10, 3'b010, 32'hDEADBEEF, 0, 0, n);
    req("rd_deadbeef", 1, 0, 32'h10, 3'b010, 0, 1, 32'hDEADBEEF, n);

    // Reset with a read in flight: no response may ever appear.
    req("rd_then_reset", 1, 0, 32'h10, 3'b010, 0, 3, 0, n);
    Reset_n = 1'b0;
    #1;
    chk("midrst_ready",  {31'd0, bus.MEM_ready},  32'd1);
    chk("midrst_data",   bus.MEM_data,            32'd0);
    chk("midrst_rvalid", {31'd0, bus.MEM_rvalid}, 32'd0);
    n_rd = 0; n_wr = 0; n_err = 0;
    @(negedge CLK);
    Reset_n = 1'b1;
    repeat (L + 3) @(negedge CLK);

    req("wr_11223344", 0, 1, 32'h10, 3'b010, 32'h11223344, 0, 0, n);
    req("wr_byte80",   0, 1, 32'h13, 3'b000, 32'h00000080, 0, 0, n);
    req("rd_w_lane",   1, 0, 32'h10, 3'b010, 0, 1, 32'h80223344, n);
    req("rd_sb_13",    1, 0, 32'h13, 3'b000, 0, 1, 32'hFFFFFF80, n);
    req("rd_ub_13",    1, 0, 32'h13, 3'b100, 0, 1, 32'h00000080, n);
    req("rd_sh_12",    1, 0, 32'h12, 3'b001, 0, 1, 32'hFFFF8022, n);
    req("rd_uh_12",    1, 0, 32'h12, 3'b101, 0, 1, 32'h00008022, n);
    req("rd_sb_11",    1, 0, 32'h11, 3'b000, 0, 1, 32'h00000033, n);
    req("wr_h_abcd",   0, 1, 32'h10, 3'b001, 32'h5555ABCD, 0, 0, n);
    req("rd_raw_w",    1, 0, 32'h10, 3'b010, 0, 1, 32'h8022ABCD, n);

    req("wr_cafef00d",  0, 1, 32'h0,    3'b010, 32'hCAFEF00D, 0, 0, n);
    req("err_half_mis", 0, 1, 32'h3,    3'b001, 32'h00001234, 2, 0, n);
    req("err_size3",    0, 1, 32'h0,    3'b011, 32'h0, 2, 0, n);
    req("err_rdwr",     1, 1, 32'h0,    3'b010, 32'h0, 2, 0, n);
    req("err_range_wr", 0, 1, 32'h1000, 3'b010, 32'h0, 2, 0, n);
    req("err_range_rd", 1, 0, 32'h1000, 3'b010, 0, 2, 0, n);
    req("err_word_mis", 1, 0, 32'h2,    3'b010, 0, 2, 0, n);
    req("rd_intact",    1, 0, 32'h0,    3'b010, 0, 1, 32'hCAFEF00D, n);
    req("wr_top_byte",  0, 1, 32'hFFF,  3'b000, 32'h0000005A, 0, 0, n);
    req("rd_top_byte",  1, 0, 32'hFFF,  3'b100, 0, 1, 32'h0000005A, n);

    // Second read is presented during RD_WAIT and must wait for ready.
    req("wr_badc0de", 0, 1, 32'h20, 3'b010, 32'h0BADC0DE, 0, 0, n);
    req("rd_a",       1, 0, 32'h10, 3'b010, 0, 1, 32'h8022ABCD, na);
    req("rd_b_held",  1, 0, 32'h20, 3'b010, 0, 1, 32'h0BADC0DE, nb);
    chk("held_accept_cycle", nb - na, L);

    k = 0;
    while (q.size() != 0 && k < 20) begin
      @(negedge CLK);
      k++;
    end
    repeat (2) @(negedge CLK);
    chk("scoreboard_drained", q.size(), 0);

`ifdef DATA_MEM_STATS_EN
    chk("stat_rd",  {16'd0, stat_rd},  n_rd);
    chk("stat_wr",  {16'd0, stat_wr},  n_wr);
    chk("stat_err", {16'd0, stat_err}, n_err);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
